lzc_normalizer: RTL and testbench
=================================

LZC_NORMALIZER -- requirements
Module: lzc_normalizer

Interface
REQ-001 SHALL have parameter WIDTH, default 24: bits per lane, minimum 2.
REQ-002 SHALL have parameter LANES, default 4: independent lanes per beat, minimum 1.
REQ-003 SHALL have parameter TAG_W, default 8: sideband tag width, carried unchanged.
REQ-004 SHALL define CW = $clog2(WIDTH+1): per-lane count width, so a count of WIDTH is representable.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1: input beat valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts the beat.
REQ-009 SHALL have port in_data, input, LANES*WIDTH: lane k in bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port in_mode, input, 1: 0 = leading-zero count, 1 = trailing-zero count; applies to all lanes of the beat.
REQ-011 SHALL have port in_tag, input, TAG_W: sideband tag.
REQ-012 SHALL have port out_valid, output, 1: output beat valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts.
REQ-014 SHALL have port out_count, output, LANES*CW: per-lane zero count.
REQ-015 SHALL have port out_zero, output, LANES: per-lane all-zero flag.
REQ-016 SHALL have port out_norm, output, LANES*WIDTH: per-lane normalised value.
REQ-017 SHALL have ports out_mode (output, 1) and out_tag (output, TAG_W): in_mode and in_tag of the same beat.

Function
REQ-018 SHALL transfer an input beat on a rising clk edge when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-019 SHALL be a two-stage pipeline. S1 registers the per-lane count, zero flag, data, mode and tag. S2 registers the normalised result.
REQ-020 SHALL produce out_valid exactly 2 cycles after acceptance when out_ready is held high, sustaining 1 beat/cycle.
REQ-021 SHALL advance each stage when it is empty or its successor advances in the same cycle; in_ready = !S1_full || S1_advances.
REQ-022 SHALL hold all S2 outputs stable while out_valid && !out_ready.
REQ-023 SHALL, in mode 0, set count to the number of consecutive zero bits from the MSB of each lane.
REQ-024 SHALL, in mode 1, set count to the number of consecutive zero bits from the LSB of each lane.
REQ-025 SHALL, for an all-zero lane, set count = WIDTH and zero = 1, and zero = 0 otherwise.
REQ-026 SHALL set norm = data << count in mode 0 and norm = data >> count in mode 1, truncated to WIDTH bits; an all-zero lane gives norm = 0.
REQ-027 SHALL complete a simultaneous accept and emit in one cycle without losing or duplicating a beat.
REQ-028 SHALL preserve beat order and never reorder lanes.
REQ-029 SHALL treat an in_valid that drops before acceptance as no transfer (no retained state).

Reset
REQ-030 SHALL, while rst_n = 0, clear S1/S2 valid flags immediately (asynchronously): out_valid = 0, in_ready = 0.
REQ-031 SHALL drive out_count, out_zero, out_norm, out_mode and out_tag to 0 during reset.
REQ-032 SHALL discard beats in flight when reset asserts mid-operation, and assert in_ready = 1 on the first clk edge after rst_n rises.

Structure
REQ-033 SHALL place the lzc_mode_e enum (LZC_LEAD = 0, LZC_TRAIL = 1) and a count-width function in shared package lzc_pkg.
REQ-034 SHALL use one combinational sub-module lzc_lane (WIDTH, mode in; count, zero out), instantiated LANES times in S1.
REQ-035 SHALL implement the S2 shifter per lane inside lzc_normalizer; no other sub-modules.

Verification (WIDTH=24, LANES=4, out_ready=1 unless stated)
REQ-036 SHALL cover: lanes {0x000001, 0x800000, 0x000000, 0x00F000}, mode 0 -> counts {23, 0, 24, 8}, zero {0, 0, 1, 0}, norm {0x800000, 0x800000, 0x000000, 0xF00000}, 2 cycles later.
REQ-037 SHALL cover: lanes {0x000100, 0x000001, 0x000000, 0x800000}, mode 1 -> counts {8, 0, 24, 23}, norm {0x000001, 0x000001, 0x000000, 0x000001}.
REQ-038 SHALL cover: out_ready=0 with in_valid held -> exactly 2 beats accepted, then in_ready=0. Raising out_ready -> beats emitted in order with tags 1, 2, 3 and no gaps.
REQ-039 SHALL cover: 100 back-to-back random beats with random out_ready -> every output matches the reference model, in order, with tags intact.
REQ-040 SHALL cover: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale beat emitted afterwards, in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/lzc_pkg.sv
// Shared types and helpers for the leading/trailing-zero normaliser.
// Holds the count-mode enum and the per-lane count-width function.
package lzc_pkg;

    typedef enum logic {
        LZC_LEAD  = 1'b0,
        LZC_TRAIL = 1'b1
    } lzc_mode_e;

    // Bits needed to hold a count of 0..width inclusive.
    function automatic int lzc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lzc_lane.sv
// One lane of zero counting: leading or trailing zeros of data_i, plus an all-zero flag.
// Purely combinational; no state and no backpressure.
module lzc_lane
    import lzc_pkg::*;
#(
    parameter int WIDTH = 24,
    localparam int CW = lzc_cw(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    output logic [CW-1:0]    count_o,
    output logic             zero_o
);

    always_comb begin
        count_o = CW'(WIDTH);
        zero_o  = ~|data_i;
        if (lzc_mode_e'(mode_i) == LZC_LEAD) begin
            // Scan upwards so the highest set bit is the last one to win.
            for (int i = 0; i < WIDTH; i++) begin
                if (data_i[i]) begin
                    count_o = CW'(WIDTH - 1 - i);
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (data_i[i]) begin
                    count_o = CW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/lzc_normalizer.sv
// Two-stage per-lane zero count (S1) and normalising shift (S2); 2-cycle latency, 1 beat/cycle.
// Valid/ready on both sides; a stalled output holds S2 and S1 keeps accepting until full.
module lzc_normalizer
    import lzc_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int LANES = 4,
    parameter int TAG_W = 8,
    localparam int CW = lzc_cw(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*CW-1:0]    out_count,
    output logic [LANES-1:0]       out_zero,
    output logic [LANES*WIDTH-1:0] out_norm,
    output logic                   out_mode,
    output logic [TAG_W-1:0]       out_tag
);

    typedef struct packed {
        logic [LANES*CW-1:0]    count;
        logic [LANES-1:0]       zero;
        logic [LANES*WIDTH-1:0] data;
        lzc_mode_e              mode;
        logic [TAG_W-1:0]       tag;
    } s1_t;

    typedef struct packed {
        logic [LANES*CW-1:0]    count;
        logic [LANES-1:0]       zero;
        logic [LANES*WIDTH-1:0] norm;
        lzc_mode_e              mode;
        logic [TAG_W-1:0]       tag;
    } s2_t;

    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic rdy_en_q;

    logic                   in_fire;
    logic                   s2_open;
    logic                   s2_load;
    logic [LANES*CW-1:0]    lane_count;
    logic [LANES-1:0]       lane_zero;
    logic [LANES*WIDTH-1:0] lane_norm;

    assign s2_open  = !s2_vld_q || out_ready;
    assign s2_load  = s1_vld_q && s2_open;
    // rdy_en_q keeps in_ready low through reset and up to the first edge after release.
    assign in_ready = rdy_en_q && (!s1_vld_q || s2_open);
    assign in_fire  = in_valid && in_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] s1_lane;
        logic [CW-1:0]    s1_cnt;

        lzc_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .data_i  (in_data[k*WIDTH +: WIDTH]),
            .mode_i  (in_mode),
            .count_o (lane_count[k*CW +: CW]),
            .zero_o  (lane_zero[k])
        );

        assign s1_lane = s1_q.data[k*WIDTH +: WIDTH];
        assign s1_cnt  = s1_q.count[k*CW +: CW];
        // A zero lane carries count = WIDTH, which shifts everything out to 0.
        assign lane_norm[k*WIDTH +: WIDTH] = (s1_q.mode == LZC_TRAIL) ? (s1_lane >> s1_cnt)
                                                                      : (s1_lane << s1_cnt);
    end

    always_comb begin
        s1_d     = s1_q;
        s1_vld_d = s1_vld_q;
        if (s2_load) begin
            s1_vld_d = 1'b0;
        end
        if (in_fire) begin
            s1_vld_d   = 1'b1;
            s1_d.count = lane_count;
            s1_d.zero  = lane_zero;
            s1_d.data  = in_data;
            s1_d.mode  = lzc_mode_e'(in_mode);
            s1_d.tag   = in_tag;
        end
    end

    always_comb begin
        s2_d     = s2_q;
        s2_vld_d = s2_vld_q;
        if (s2_vld_q && out_ready) begin
            s2_vld_d = 1'b0;
        end
        if (s2_load) begin
            s2_vld_d   = 1'b1;
            s2_d.count = s1_q.count;
            s2_d.zero  = s1_q.zero;
            s2_d.norm  = lane_norm;
            s2_d.mode  = s1_q.mode;
            s2_d.tag   = s1_q.tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            rdy_en_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            rdy_en_q <= 1'b1;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_count = s2_q.count;
    assign out_zero  = s2_q.zero;
    assign out_norm  = s2_q.norm;
    assign out_mode  = s2_q.mode;
    assign out_tag   = s2_q.tag;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Bench for lzc_normalizer: fixed vectors, backpressure, random traffic against a
// reference model, and reset with beats in flight.
module tb_lzc_normalizer;

    localparam int WIDTH = 24;
    localparam int LANES = 4;
    localparam int TAG_W = 8;
    localparam int CW    = 5;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_mode;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*CW-1:0]    out_count;
    logic [LANES-1:0]       out_zero;
    logic [LANES*WIDTH-1:0] out_norm;
    logic                   out_mode;
    logic [TAG_W-1:0]       out_tag;

    lzc_normalizer #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero),
        .out_norm  (out_norm),
        .out_mode  (out_mode),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic                   mode;
        logic [TAG_W-1:0]       tag;
        logic [LANES*CW-1:0]    cnt;
        logic [LANES-1:0]       zero;
        logic [LANES*WIDTH-1:0] norm;
    } beat_t;

    typedef struct packed {
        logic [3:0][23:0] d;
        logic             mode;
        logic [3:0][4:0]  cnt;
        logic [3:0]       zero;
        logic [3:0][23:0] norm;
    } vec_t;

    vec_t  vec [5];
    beat_t sb [$];
    beat_t mon_exp;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: leading zeros from the position of the top set bit, trailing zeros
    // from the isolated lowest set bit (a power of two, so $clog2 is exact).
    function automatic logic [4:0] ref_cnt(input logic [23:0] d, input logic m);
        if (d == 24'd0) return 5'd24;
        if (!m) return 5'(24 - $clog2(int'(d) + 1));
        return 5'($clog2(int'(d & (~d + 24'd1))));
    endfunction

    function automatic beat_t model(input logic [95:0] d, input logic m, input logic [7:0] t);
        beat_t b;
        b.mode = m;
        b.tag  = t;
        for (int k = 0; k < LANES; k++) begin
            logic [23:0] v;
            logic [4:0]  c;
            v = d[k*24 +: 24];
            c = ref_cnt(v, m);
            b.cnt[k*5 +: 5]   = c;
            b.zero[k]         = (v == 24'd0);
            b.norm[k*24 +: 24] = m ? (v >> c) : (v << c);
        end
        return b;
    endfunction

    function automatic logic [95:0] rnd_data();
        logic [95:0] r;
        for (int k = 0; k < LANES; k++) begin
            logic [23:0] v;
            v = 24'($urandom) >> $urandom_range(0, 24);
            v = v << $urandom_range(0, 23);
            if ($urandom_range(0, 7) == 0) v = 24'd0;
            r[k*24 +: 24] = v;
        end
        return r;
    endfunction

    // Scoreboard: every emitted beat must match the oldest accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 160'(out_valid), 160'(0));
                end else begin
                    mon_exp = sb.pop_front();
                    chk("stream", 160'({out_mode, out_tag, out_count, out_zero, out_norm}),
                        160'(mon_exp));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, in_mode, in_tag));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic run_vec(input int i);
        @(posedge clk); #1;
        in_data  = vec[i].d;
        in_mode  = vec[i].mode;
        in_tag   = 8'(8'h40 + i);
        in_valid = 1'b1;
        @(negedge clk);
        chk("vec_in_ready", 160'(in_ready), 160'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("vec_lat_c1", 160'(out_valid), 160'(0));
        @(negedge clk);
        chk("vec_lat_c2", 160'(out_valid), 160'(1));
        chk("vec_count", 160'(out_count), 160'(vec[i].cnt));
        chk("vec_zero", 160'(out_zero), 160'(vec[i].zero));
        chk("vec_norm", 160'(out_norm), 160'(vec[i].norm));
        chk("vec_tag", 160'({out_mode, out_tag}), 160'({vec[i].mode, 8'(8'h40 + i)}));
        repeat (2) @(posedge clk);
    endtask

    int    acc;
    int    cyc;
    bit    took;
    int    n_out;
    int    out_cyc [3];
    logic [7:0] out_tags [3];
    logic [7:0] tag;
    beat_t b1;

    initial begin
        vec[0].d    = {24'h00F000, 24'h000000, 24'h800000, 24'h000001};
        vec[0].mode = 1'b0;
        vec[0].cnt  = {5'd8, 5'd24, 5'd0, 5'd23};
        vec[0].zero = 4'b0100;
        vec[0].norm = {24'hF00000, 24'h000000, 24'h800000, 24'h800000};
        vec[1].d    = {24'h800000, 24'h000000, 24'h000001, 24'h000100};
        vec[1].mode = 1'b1;
        vec[1].cnt  = {5'd23, 5'd24, 5'd0, 5'd8};
        vec[1].zero = 4'b0100;
        vec[1].norm = {24'h000001, 24'h000000, 24'h000001, 24'h000001};
        vec[2].d    = {24'h123456, 24'h000002, 24'h400000, 24'hFFFFFF};
        vec[2].mode = 1'b0;
        vec[2].cnt  = {5'd3, 5'd22, 5'd1, 5'd0};
        vec[2].zero = 4'b0000;
        vec[2].norm = {24'h91A2B0, 24'h800000, 24'h800000, 24'hFFFFFF};
        vec[3].d    = {24'h123456, 24'h000002, 24'h400000, 24'hFFFFFF};
        vec[3].mode = 1'b1;
        vec[3].cnt  = {5'd1, 5'd1, 5'd22, 5'd0};
        vec[3].zero = 4'b0000;
        vec[3].norm = {24'h091A2B, 24'h000001, 24'h000001, 24'hFFFFFF};
        vec[4].d    = '0;
        vec[4].mode = 1'b1;
        vec[4].cnt  = {5'd24, 5'd24, 5'd24, 5'd24};
        vec[4].zero = 4'b1111;
        vec[4].norm = '0;

        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_in_ready", 160'(in_ready), 160'(0));
        chk("rst_outputs", 160'({out_count, out_zero, out_norm, out_mode, out_tag}), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_pre_edge", 160'(in_ready), 160'(0));
        @(posedge clk); #1;
        chk("rel_rdy_post_edge", 160'(in_ready), 160'(1));

        for (int i = 0; i < 5; i++) run_vec(i);

        // Backpressure: out_ready low, in_valid held, tags 1,2,3
        @(posedge clk); #1;
        out_ready = 1'b0;
        tag       = 8'd1;
        in_tag    = tag;
        in_data   = rnd_data();
        in_mode   = 1'($urandom);
        b1        = model(in_data, in_mode, 8'd1);
        in_valid  = 1'b1;
        acc       = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            @(posedge clk); #1;
            if (took) begin
                tag     = tag + 8'd1;
                in_tag  = tag;
                in_data = rnd_data();
                in_mode = 1'($urandom);
            end
        end
        chk("bp_accepted", 160'(acc), 160'(2));
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("bp_rdy_low", 160'(in_ready), 160'(0));
            chk("bp_hold", 160'({out_valid, out_mode, out_tag, out_count, out_zero, out_norm}),
                160'({1'b1, b1}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n_out     = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (out_valid && n_out < 3) begin
                out_tags[n_out] = out_tag;
                out_cyc[n_out]  = n;
                n_out++;
            end
            @(posedge clk); #1;
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_out_count", 160'(n_out), 160'(3));
        for (int k = 0; k < 3; k++) begin
            if (k < n_out) begin
                chk("bp_out_tag", 160'(out_tags[k]), 160'(k + 1));
                chk("bp_out_gapless", 160'(out_cyc[k]), 160'(k));
            end
        end

        // Random traffic with random out_ready
        acc = 0;
        cyc = 0;
        tag = 8'h80;
        in_tag   = tag;
        in_data  = rnd_data();
        in_mode  = 1'($urandom);
        in_valid = 1'b1;
        while (acc < 100 && cyc < 3000) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) acc++;
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (took || !in_valid) begin
                tag      = tag + 8'd1;
                in_tag   = tag;
                in_data  = rnd_data();
                in_mode  = 1'($urandom);
                in_valid = ($urandom_range(0, 7) != 0);
            end else if ($urandom_range(0, 15) == 0) begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", 160'(acc), 160'(100));
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        chk("rand_drained", 160'(sb.size()), 160'(0));

        // Reset with two beats in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_data   = rnd_data();
        in_mode   = 1'b0;
        in_tag    = 8'hE0;
        in_valid  = 1'b1;
        acc       = 0;
        for (int n = 0; n < 10 && acc < 2; n++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++;
                in_tag  = in_tag + 8'd1;
                in_data = rnd_data();
            end
        end
        in_valid = 1'b0;
        chk("rst_inflight_acc", 160'(acc), 160'(2));
        chk("rst_inflight_vld", 160'(out_valid), 160'(1));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_out_valid", 160'(out_valid), 160'(0));
        chk("mid_rst_in_ready", 160'(in_ready), 160'(0));
        chk("mid_rst_outputs", 160'({out_count, out_zero, out_norm, out_mode, out_tag}), 160'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_rdy_pre", 160'(in_ready), 160'(0));
        @(posedge clk); #1;
        chk("mid_rel_rdy_post", 160'(in_ready), 160'(1));
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("no_stale_beat", 160'(out_valid), 160'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
